// File: rtl/ramchk_pkg.sv
// Shared types for the dual-port RAM co-simulation checker.
// Defines the run-state encoding, default sizes and the read tag bundle.
package ramchk_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
  } tag_t;

endpackage

// File: rtl/ramchk_tag_pipe.sv
// RD_LAT-deep tag delay line: clk/rst_n (async clear), flush (sync clear),
// din tag pushed each cycle, dout is the tag issued RD_LAT cycles ago.
module ramchk_tag_pipe
  import ramchk_pkg::*;
#(
  parameter int  DEPTH = DEF_RD_LAT,
  parameter type ptag_t = tag_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  ptag_t din,
  output ptag_t dout
);

  ptag_t q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      q[0] <= din;
      for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
    end
  end

  assign dout = q[DEPTH-1];

endmodule

// File: rtl/ram_dp_cosim_checker.sv
// Compares golden vs netlist dual-port RAM read data on returning reads,
// with saturating check/mismatch counters and a busy/done/pass summary.
// Ports: clk, rst_n, start, stop, reA/B, addrA/B, doutA/B(_net) in;
// busy, done, pass, checks_cnt, mismatch_cnt, first_err_* out.
// RAMCHK_FIRST_ERR_EN enables the sticky first-failure record.
module ram_dp_cosim_checker
  import ramchk_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              reA,
  input  logic              reB,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] doutA,
  input  logic [DATA_W-1:0] doutB,
  input  logic [DATA_W-1:0] doutA_net,
  input  logic [DATA_W-1:0] doutB_net,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  checks_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              first_err_valid,
  output logic              first_err_port,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } ptag_t;

  localparam int DW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);

  state_t        st, st_n;
  logic [DW-1:0] dcnt;
  logic          clr;
  ptag_t         ina, inb, ta, tb;
  logic          faila, failb;
  logic [1:0]    inc_chk, inc_mis;
  logic [CNT_W:0] sum_chk, sum_mis;

  // A run restarts only from IDLE/DONE; start elsewhere is ignored.
  assign clr = start && (st == IDLE || st == DONE);

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE, DONE: if (start) st_n = RUN;
      RUN:        if (stop) st_n = DRAIN;
      DRAIN:      if (dcnt == DW'(RD_LAT - 1)) st_n = DONE;
      default:    st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             dcnt <= '0;
    else if (st == DRAIN)   dcnt <= dcnt + 1'b1;
    else                    dcnt <= '0;
  end

  assign ina = '{valid: reA && st == RUN, addr: addrA};
  assign inb = '{valid: reB && st == RUN, addr: addrB};

  ramchk_tag_pipe #(.DEPTH(RD_LAT), .ptag_t(ptag_t)) u_pipe_a (
    .clk(clk), .rst_n(rst_n), .flush(clr), .din(ina), .dout(ta)
  );

  ramchk_tag_pipe #(.DEPTH(RD_LAT), .ptag_t(ptag_t)) u_pipe_b (
    .clk(clk), .rst_n(rst_n), .flush(clr), .din(inb), .dout(tb)
  );

  assign faila   = ta.valid && (doutA != doutA_net);
  assign failb   = tb.valid && (doutB != doutB_net);
  assign inc_chk = {1'b0, ta.valid} + {1'b0, tb.valid};
  assign inc_mis = {1'b0, faila} + {1'b0, failb};
  assign sum_chk = {1'b0, checks_cnt} + (CNT_W+1)'(inc_chk);
  assign sum_mis = {1'b0, mismatch_cnt} + (CNT_W+1)'(inc_mis);

  // Carry out of the widened sum means the counter would wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checks_cnt   <= '0;
      mismatch_cnt <= '0;
    end else if (clr) begin
      checks_cnt   <= '0;
      mismatch_cnt <= '0;
    end else begin
      checks_cnt   <= sum_chk[CNT_W] ? '1 : sum_chk[CNT_W-1:0];
      mismatch_cnt <= sum_mis[CNT_W] ? '1 : sum_mis[CNT_W-1:0];
    end
  end

  assign busy = (st == RUN) || (st == DRAIN);
  assign done = (st == DONE);
  assign pass = done && (mismatch_cnt == '0);

`ifdef RAMCHK_FIRST_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_valid <= 1'b0;
      first_err_port  <= 1'b0;
      first_err_addr  <= '0;
      first_err_exp   <= '0;
      first_err_got   <= '0;
    end else if (clr) begin
      first_err_valid <= 1'b0;
      first_err_port  <= 1'b0;
      first_err_addr  <= '0;
      first_err_exp   <= '0;
      first_err_got   <= '0;
    end else if (!first_err_valid && (faila || failb)) begin
      // Port A takes precedence when both fail together.
      first_err_valid <= 1'b1;
      first_err_port  <= !faila;
      first_err_addr  <= faila ? ta.addr : tb.addr;
      first_err_exp   <= faila ? doutA : doutB;
      first_err_got   <= faila ? doutA_net : doutB_net;
    end
  end
`else
  logic unused_tag_addr;
  assign unused_tag_addr = ^{ta.addr, tb.addr};
  assign first_err_valid = 1'b0;
  assign first_err_port  = 1'b0;
  assign first_err_addr  = '0;
  assign first_err_exp   = '0;
  assign first_err_got   = '0;
`endif

endmodule
